// File: rtl/arch_defs_pkg.sv
// Architecture-wide definitions for the SAP-2 CPU datapath.
// Holds the program-counter operation and branch-condition encodings
// used between the control unit and branch_pc_unit, plus the default
// depth of the return-address stack.
package arch_defs_pkg;

    localparam int STACK_DEPTH_DEF = 4;

    // Program-counter micro-operation. Encodings 5..7 are unused and
    // behave as PC_NOP.
    typedef enum logic [2:0] {
        PC_NOP  = 3'd0,
        PC_INC  = 3'd1,
        PC_JMP  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_t;

    // Branch condition tested against the latched ALU flags. Encoding 7
    // is unused and never satisfied.
    typedef enum logic [2:0] {
        C_ALWAYS = 3'd0,
        C_Z      = 3'd1,
        C_NZ     = 3'd2,
        C_C      = 3'd3,
        C_NC     = 3'd4,
        C_N      = 3'd5,
        C_NN     = 3'd6
    } cond_t;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address stack for branch_pc_unit.
// Ports:
//   clk, reset (async, active-low)  - clock and reset; reset clears sp only
//   push, din                        - write din at slot sp, sp+1 (ignored when full)
//   pop, dout                        - dout always shows the top entry; pop does sp-1
//   sp                               - number of occupied entries
//   full, empty                      - sp==STACK_DEPTH / sp==0
module pc_return_stack
    import arch_defs_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_WIDTH-1:0]          din,
    output logic [ADDR_WIDTH-1:0]          dout,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           full,
    output logic                           empty
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_V = PW'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]         sp_q;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (sp_q == DEPTH_V);
    assign empty   = (sp_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    // With a power-of-two depth, sp==DEPTH has all-zero low bits, so the
    // wrapped decrement still lands on the top slot.
    assign wr_idx = sp_q[IW-1:0];
    assign rd_idx = sp_q[IW-1:0] - IW'(1);
    assign dout   = mem[rd_idx];
    assign sp     = sp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
        end else if (do_push) begin
            sp_q <= sp_q + ONE;
        end else if (do_pop) begin
            sp_q <= sp_q - ONE;
        end
    end

    // Storage is deliberately left unreset; sp alone decides visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter and branch unit for the SAP-2 CPU.
// Ports:
//   clk, reset (async, active-low)
//   pc_op, cond                  - micro-operation and branch condition
//   flag_*_i                     - latched ALU zero/carry/negative flags
//   target                       - jump/call destination from the bus
//   halt                         - freezes all state, suppresses taken
//   counter_out                  - current PC (drives MAR)
//   taken                        - one-cycle pulse after a successful transfer
//   sp                           - occupied return-stack entries
//   stack_overflow/underflow     - sticky error flags, cleared only by reset
module branch_pc_unit
    import arch_defs_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  pc_op_t                        pc_op,
    input  cond_t                         cond,
    input  logic                          flag_zero_i,
    input  logic                          flag_carry_i,
    input  logic                          flag_negative_i,
    input  logic [ADDR_WIDTH-1:0]         target,
    input  logic                          halt,
    output logic [ADDR_WIDTH-1:0]         counter_out,
    output logic                          taken,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic                          stack_overflow,
    output logic                          stack_underflow
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  taken_q, taken_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  cond_met;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic                  full, empty;

    pc_return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_q),
        .dout  (ret_addr),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        cond_met = 1'b0;
        case (cond)
            C_ALWAYS: cond_met = 1'b1;
            C_Z:      cond_met = flag_zero_i;
            C_NZ:     cond_met = !flag_zero_i;
            C_C:      cond_met = flag_carry_i;
            C_NC:     cond_met = !flag_carry_i;
            C_N:      cond_met = flag_negative_i;
            C_NN:     cond_met = !flag_negative_i;
            default:  cond_met = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!halt) begin
            case (pc_op)
                PC_INC: pc_d = pc_q + ADDR_WIDTH'(1);
                PC_JMP: begin
                    if (cond_met) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                PC_CALL: begin
                    // A false condition skips the full check entirely.
                    if (cond_met) begin
                        if (!full) begin
                            push    = 1'b1;
                            pc_d    = target;
                            taken_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                PC_RET: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        pc_d    = ret_addr;
                        taken_d = 1'b1;
                    end else begin
                        udf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign counter_out     = pc_q;
    assign taken           = taken_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = udf_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;
    import arch_defs_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 8-bit instance, depth 4
    pc_op_t     op8;
    cond_t      cd8;
    logic       fz, fc, fn, halt8;
    logic [7:0] tgt8;
    logic [7:0] pc8;
    logic       tk8, ovf8, udf8;
    logic [2:0] sp8;

    // 12-bit instance, depth 4
    pc_op_t      op12;
    cond_t       cd12;
    logic [11:0] tgt12;
    logic [11:0] pc12;
    logic        tk12, ovf12, udf12;
    logic [2:0]  sp12;

    int total_cnt = 0;
    int pass_cnt  = 0;

    branch_pc_unit #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut8 (
        .clk(clk), .reset(reset), .pc_op(op8), .cond(cd8),
        .flag_zero_i(fz), .flag_carry_i(fc), .flag_negative_i(fn),
        .target(tgt8), .halt(halt8), .counter_out(pc8), .taken(tk8),
        .sp(sp8), .stack_overflow(ovf8), .stack_underflow(udf8)
    );

    branch_pc_unit #(.ADDR_WIDTH(12), .STACK_DEPTH(4)) dut12 (
        .clk(clk), .reset(reset), .pc_op(op12), .cond(cd12),
        .flag_zero_i(1'b0), .flag_carry_i(1'b0), .flag_negative_i(1'b0),
        .target(tgt12), .halt(1'b0), .counter_out(pc12), .taken(tk12),
        .sp(sp12), .stack_overflow(ovf12), .stack_underflow(udf12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one op to the 8-bit instance and wait past the edge.
    task automatic step(input pc_op_t op, input cond_t c, input logic [7:0] t);
        op8  = op;
        cd8  = c;
        tgt8 = t;
        tick();
        op8 = PC_NOP;
    endtask

    task automatic chk8(input string tag, input logic [7:0] pc, input logic tk, input logic [2:0] sp);
        chk({tag, ".pc"}, 32'(pc8), 32'(pc));
        chk({tag, ".taken"}, 32'(tk8), 32'(tk));
        chk({tag, ".sp"}, 32'(sp8), 32'(sp));
    endtask

    initial begin
        reset = 1'b0;
        op8 = PC_NOP; cd8 = C_ALWAYS; tgt8 = '0; fz = 0; fc = 0; fn = 0; halt8 = 0;
        op12 = PC_NOP; cd12 = C_ALWAYS; tgt12 = '0;
        tick();
        tick();
        chk8("reset", 8'h00, 1'b0, 3'd0);
        chk("reset.ovf", 32'(ovf8), 32'd0);
        chk("reset.udf", 32'(udf8), 32'd0);
        chk("reset.pc12", 32'(pc12), 32'h000);
        reset = 1'b1;

        // Increment and wrap
        step(PC_INC, C_ALWAYS, 8'h00);
        step(PC_INC, C_ALWAYS, 8'h00);
        step(PC_INC, C_ALWAYS, 8'h00);
        chk8("inc3", 8'h03, 1'b0, 3'd0);
        step(PC_JMP, C_ALWAYS, 8'hFF);
        chk8("jmp_ff", 8'hFF, 1'b1, 3'd0);
        step(PC_INC, C_ALWAYS, 8'h00);
        chk8("wrap", 8'h00, 1'b0, 3'd0);

        // Carry conditions
        fc = 1;
        step(PC_JMP, C_C, 8'h06);
        chk8("jc_taken", 8'h06, 1'b1, 3'd0);
        step(PC_NOP, C_ALWAYS, 8'h00);
        chk8("taken_pulse", 8'h06, 1'b0, 3'd0);
        step(PC_INC, C_ALWAYS, 8'h00);
        fc = 0;
        step(PC_JMP, C_C, 8'h0A);
        chk8("jc_not", 8'h07, 1'b0, 3'd0);
        step(PC_JMP, C_NC, 8'h20);
        chk8("jnc", 8'h20, 1'b1, 3'd0);

        // Zero / negative conditions
        fz = 1;
        step(PC_JMP, C_Z, 8'h30);
        chk8("jz", 8'h30, 1'b1, 3'd0);
        step(PC_JMP, C_NZ, 8'h50);
        chk8("jnz_not", 8'h30, 1'b0, 3'd0);
        fn = 0;
        step(PC_JMP, C_N, 8'h55);
        chk8("jn_not", 8'h30, 1'b0, 3'd0);
        step(PC_JMP, C_NN, 8'h31);
        chk8("jnn", 8'h31, 1'b1, 3'd0);
        fn = 1;
        step(PC_JMP, C_N, 8'h10);
        chk8("jn", 8'h10, 1'b1, 3'd0);
        fz = 0;
        step(PC_JMP, C_Z, 8'h77);
        chk8("jz_not", 8'h10, 1'b0, 3'd0);

        // Nested call / return
        step(PC_CALL, C_ALWAYS, 8'h40);
        chk8("call1", 8'h40, 1'b1, 3'd1);
        step(PC_INC, C_ALWAYS, 8'h00);
        step(PC_CALL, C_ALWAYS, 8'h80);
        chk8("call2", 8'h80, 1'b1, 3'd2);
        step(PC_RET, C_ALWAYS, 8'h00);
        chk8("ret1", 8'h41, 1'b1, 3'd1);
        step(PC_RET, C_ALWAYS, 8'h00);
        chk8("ret2", 8'h10, 1'b1, 3'd0);

        // Conditional call with false condition
        fc = 0;
        step(PC_CALL, C_C, 8'h99);
        chk8("call_false", 8'h10, 1'b0, 3'd0);

        // Overflow
        step(PC_CALL, C_ALWAYS, 8'hA1);
        step(PC_CALL, C_ALWAYS, 8'hA2);
        step(PC_CALL, C_ALWAYS, 8'hA3);
        step(PC_CALL, C_ALWAYS, 8'hA4);
        chk8("call4", 8'hA4, 1'b1, 3'd4);
        chk("call4.ovf", 32'(ovf8), 32'd0);
        step(PC_CALL, C_C, 8'hB1);
        chk("full_false.ovf", 32'(ovf8), 32'd0);
        step(PC_CALL, C_ALWAYS, 8'hB0);
        chk8("call5", 8'hA4, 1'b0, 3'd4);
        chk("call5.ovf", 32'(ovf8), 32'd1);

        // Unwind and underflow
        step(PC_RET, C_ALWAYS, 8'h00);
        chk8("unw1", 8'hA3, 1'b1, 3'd3);
        step(PC_RET, C_ALWAYS, 8'h00);
        chk8("unw2", 8'hA2, 1'b1, 3'd2);
        step(PC_RET, C_ALWAYS, 8'h00);
        chk8("unw3", 8'hA1, 1'b1, 3'd1);
        step(PC_RET, C_ALWAYS, 8'h00);
        chk8("unw4", 8'h10, 1'b1, 3'd0);
        chk("unw4.udf", 32'(udf8), 32'd0);
        step(PC_RET, C_ALWAYS, 8'h00);
        chk8("ret_empty", 8'h10, 1'b0, 3'd0);
        chk("ret_empty.udf", 32'(udf8), 32'd1);
        chk("ret_empty.ovf", 32'(ovf8), 32'd1);

        // Undefined op acts as NOP
        op8 = pc_op_t'(3'd7);
        tick();
        chk8("undef_op", 8'h10, 1'b0, 3'd0);

        // Halt freezes everything
        halt8 = 1;
        for (int i = 0; i < 5; i++) step(PC_INC, C_ALWAYS, 8'h00);
        chk8("halt_inc", 8'h10, 1'b0, 3'd0);
        step(PC_JMP, C_ALWAYS, 8'h66);
        chk8("halt_jmp", 8'h10, 1'b0, 3'd0);
        halt8 = 0;

        // Asynchronous reset mid-call sequence
        step(PC_CALL, C_ALWAYS, 8'h40);
        chk8("pre_rst", 8'h40, 1'b1, 3'd1);
        op8 = PC_CALL; tgt8 = 8'h50;
        #1;
        reset = 1'b0;
        #1;
        chk8("async_rst", 8'h00, 1'b0, 3'd0);
        chk("async_rst.ovf", 32'(ovf8), 32'd0);
        chk("async_rst.udf", 32'(udf8), 32'd0);
        op8 = PC_NOP;
        tick();
        reset = 1'b1;
        step(PC_INC, C_ALWAYS, 8'h00);
        chk8("post_rst_inc", 8'h01, 1'b0, 3'd0);

        // 12-bit instance: wrap and full-width round trip
        op12 = PC_JMP; cd12 = C_ALWAYS; tgt12 = 12'hFFF;
        tick();
        chk("w12.jmp", 32'(pc12), 32'hFFF);
        op12 = PC_INC;
        tick();
        chk("w12.wrap", 32'(pc12), 32'h000);
        op12 = PC_JMP; tgt12 = 12'h9A5;
        tick();
        op12 = PC_CALL; tgt12 = 12'h123;
        tick();
        chk("w12.call", 32'(pc12), 32'h123);
        chk("w12.sp", 32'(sp12), 32'd1);
        op12 = PC_RET;
        tick();
        chk("w12.ret", 32'(pc12), 32'h9A5);
        chk("w12.taken", 32'(tk12), 32'd1);
        op12 = PC_NOP;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Parametrised program-counter and branch unit for the SAP-2 CPU. It replaces the fixed 8-bit counter with unconditional/carry jumps. It supports increment, conditional jump on any ALU flag or its complement, conditional CALL, and RET through an internal return-address stack of configurable depth. The control unit drives it one micro-step at a time. Its output feeds the MAR/address bus exactly as the current program counter's does.

## Interface
- ADDR_WIDTH, 8: width of program counter and jump targets.
- STACK_DEPTH, 4: number of return-address entries; power of two, at least 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_op  in  3  operation, type pc_op_t: PC_NOP, PC_INC, PC_JMP, PC_CALL, PC_RET.
- cond  in  3  branch condition, type cond_t: C_ALWAYS, C_Z, C_NZ, C_C, C_NC, C_N, C_NN.
- flag_zero_i, flag_carry_i, flag_negative_i  in  1 each  latched ALU flags.
- target  in  ADDR_WIDTH  jump/call destination, taken from the bus.
- halt  in  1  freezes all state while high.
- counter_out  out  ADDR_WIDTH  current PC; reset value 0.
- taken  out  1  registered pulse, high for one cycle after a JMP/CALL whose condition held, or after a successful RET; reset 0.
- sp  out  $clog2(STACK_DEPTH)+1  number of occupied stack entries; reset 0.
- stack_overflow  out  1  sticky error flag; reset 0.
- stack_underflow  out  1  sticky error flag; reset 0.

## Operation
- cond_met: ALWAYS→1; Z/NZ→flag_zero_i or its inverse; C/NC→carry; N/NN→negative. Flags are sampled on the same edge as pc_op.
- PC_NOP: hold.
- PC_INC: counter_out+1, wrapping modulo 2^ADDR_WIDTH (max→0).
- PC_JMP: if cond_met, counter_out←target and taken=1; else hold and taken=0.
- PC_CALL: if cond_met and sp<STACK_DEPTH, push counter_out, load target, set sp+1 and taken=1. The return address is the current PC; microcode has already advanced past the operand.
- PC_CALL with cond_met and sp==STACK_DEPTH: no push, PC holds, taken=0, stack_overflow←1.
- PC_CALL with cond false: nothing changes, and the stack-full check is not made.
- PC_RET (cond ignored): if sp>0, pop the top entry into counter_out, set sp−1 and taken=1. If sp==0, PC holds, taken=0, stack_underflow←1.
- halt high: pc_op is ignored, taken=0, and the error flags hold.
- Error flags clear only on reset. Stack contents are not reset; sp=0 makes them invisible.
- Undefined pc_op encodings act as PC_NOP.

## Timing
- Single-cycle latency: the op sampled at edge N is visible on counter_out, sp and taken after edge N.
- taken is high exactly one cycle per successful transfer. Back-to-back transfers keep it high on consecutive cycles.
- Reset asserted at any time, including mid-CALL: all outputs go to reset values immediately. The first op is accepted on the first rising edge after release.
- Only one op per cycle, so there is no CALL/RET collision. Push and pop address the stack array through sp alone.

## Structure
- arch_defs_pkg gains pc_op_t, cond_t and the STACK_DEPTH default constant.
- Sub-module pc_return_stack (parameters ADDR_WIDTH and STACK_DEPTH). It has push, pop, data in/out, sp, full and empty, and register-array storage. branch_pc_unit holds the PC register, condition decode and error flags.
- The existing computer top instantiates it as u_program_counter, so benches keep reading counter_out.

## Test plan
- Reset, then 3× PC_INC → counter_out=0x03, taken=0. Set counter_out=0xFF via JMP, then INC → 0x00.
- flag_carry_i=1, PC_JMP C_C target=0x06 → counter_out=0x06, taken=1 for one cycle. Then carry=0 at PC=0x07, PC_JMP C_C target=0x0A → PC stays 0x07, taken=0. Repeat for Z/NZ and N/NN.
- At PC=0x10, PC_CALL ALWAYS target=0x40 → PC=0x40, sp=1. At PC=0x41, CALL target=0x80 → sp=2. RET → PC=0x41, sp=1. RET → PC=0x10, sp=0.
- STACK_DEPTH=4: five successful-condition CALLs → fifth leaves PC unchanged, sp=4, stack_overflow=1. Four RETs unwind correctly, then a fifth RET sets stack_underflow=1 and PC holds.
- halt=1 with PC_INC for 5 cycles → counter_out unchanged. Assert reset (low) between CALL cycles → counter_out=0, sp=0, both error flags 0 immediately, without waiting for a clock edge.
- ADDR_WIDTH=12 instance: JMP target=0xFFF, INC → 0x000. CALL/RET round-trip preserves all 12 bits.
